// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS control pipeline.
// Control bundle layout, MSB first:
// {RegDst, J, Beq, Bneq, MemRead, MemtoReg, MemWrite, RegWrite, Alu_src[1:0], Alu_op[2:0]}
package mips_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CTRL_W = 13;

    // Bit positions of each control field
    localparam int unsigned B_REGDST    = 12;
    localparam int unsigned B_J         = 11;
    localparam int unsigned B_BEQ       = 10;
    localparam int unsigned B_BNEQ      = 9;
    localparam int unsigned B_MEMREAD   = 8;
    localparam int unsigned B_MEMTOREG  = 7;
    localparam int unsigned B_MEMWRITE  = 6;
    localparam int unsigned B_REGWRITE  = 5;
    localparam int unsigned B_ALUSRC_HI = 4;
    localparam int unsigned B_ALUSRC_LO = 3;
    localparam int unsigned B_ALUOP_HI  = 2;
    localparam int unsigned B_ALUOP_LO  = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    // ALU operand source select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Fields carried into the EX/MEM register
    typedef struct packed {
        logic              memread;
        logic              memwrite;
        logic              memtoreg;
        logic              regwrite;
        logic [REG_AW-1:0] dst;
    } mem_stage_t;

    // Clear decoder don't-care fields before they enter the pipeline
    function automatic logic [CTRL_W-1:0] ctrl_sanitize(input logic [CTRL_W-1:0] c);
        logic [CTRL_W-1:0] s;
        s = c;
        if (!c[B_REGWRITE]) begin
            s[B_REGDST]   = 1'b0;
            s[B_MEMTOREG] = 1'b0;
        end
        if (c[B_J]) begin
            s[B_ALUSRC_HI:B_ALUSRC_LO] = '0;
            s[B_ALUOP_HI:B_ALUOP_LO]   = '0;
        end
        return s;
    endfunction

endpackage

// File: rtl/mips_ctrl_pipe_if.sv
// Bundle between the decoder/datapath side (master) and the control pipeline (slave).
// With CTRL_PIPE_PERF_EN defined, stall/flush event counters are added.
interface mips_ctrl_pipe_if;
    import mips_ctrl_pkg::*;

    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_zero;
    logic              stall;
    logic              flush;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              mem_memread;
    logic              mem_memwrite;
    logic              mem_regwrite;
    logic              mem_memtoreg;
    logic [REG_AW-1:0] mem_dst;
    logic              wb_regwrite;
    logic              wb_memtoreg;
    logic [REG_AW-1:0] wb_dst;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
`ifdef CTRL_PIPE_PERF_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
`endif

    modport master (
        output id_ctrl, id_rs, id_rt, id_rd, ex_zero,
        input  stall, flush, ex_ctrl, ex_rs, ex_rt,
        input  mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_dst,
        input  wb_regwrite, wb_memtoreg, wb_dst, fwd_a, fwd_b
`ifdef CTRL_PIPE_PERF_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_ctrl, id_rs, id_rt, id_rd, ex_zero,
        output stall, flush, ex_ctrl, ex_rs, ex_rt,
        output mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_dst,
        output wb_regwrite, wb_memtoreg, wb_dst, fwd_a, fwd_b
`ifdef CTRL_PIPE_PERF_EN
        , output stall_cnt, flush_cnt
`endif
    );

endinterface

// File: rtl/mips_fwd_unit.sv
// ALU operand forwarding selects. EX/MEM has priority over MEM/WB; $0 never forwards.
module mips_fwd_unit
    import mips_ctrl_pkg::*;
(
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    function automatic fwd_sel_e pick(input logic              m_we,
                                      input logic [REG_AW-1:0] m_dst,
                                      input logic              w_we,
                                      input logic [REG_AW-1:0] w_dst,
                                      input logic [REG_AW-1:0] src);
        if (m_we && (m_dst != '0) && (m_dst == src)) return FWD_MEM;
        if (w_we && (w_dst != '0) && (w_dst == src)) return FWD_WB;
        return FWD_REG;
    endfunction

    // Select source for each ALU operand
    always_comb begin
        fwd_a = pick(mem_regwrite, mem_dst, wb_regwrite, wb_dst, ex_rs);
        fwd_b = pick(mem_regwrite, mem_dst, wb_regwrite, wb_dst, ex_rt);
    end

endmodule

// File: rtl/mips_ctrl_pipe.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with branch resolution in EX,
// load-use stall detection and forwarding selects.
// Optional: CTRL_PIPE_PERF_EN adds saturating stall/flush event counters.
module mips_ctrl_pipe
    import mips_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mips_ctrl_pipe_if.slave bus
);

    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_rd_q;
    mem_stage_t        mem_q;
    logic              wb_regwrite_q;
    logic              wb_memtoreg_q;
    logic [REG_AW-1:0] wb_dst_q;

    logic [REG_AW-1:0] ex_dst;
    logic              taken;
    logic              id_uses_rt;
    logic              load_use;
    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    // Branch resolution and load-use detection; a taken branch overrides the stall
    always_comb begin
        ex_dst     = ex_ctrl_q[B_REGDST] ? ex_rd_q : ex_rt_q;
        taken      = ex_ctrl_q[B_J]
                   | (ex_ctrl_q[B_BEQ]  &  bus.ex_zero)
                   | (ex_ctrl_q[B_BNEQ] & ~bus.ex_zero);
        id_uses_rt = (bus.id_ctrl[B_ALUSRC_HI:B_ALUSRC_LO] == 2'b00) | bus.id_ctrl[B_MEMWRITE];
        load_use   = ex_ctrl_q[B_MEMREAD] & (ex_dst != '0)
                   & ((ex_dst == bus.id_rs) | ((ex_dst == bus.id_rt) & id_uses_rt));
        stall      = load_use & ~taken;
    end

    // Stage registers; ID/EX takes a bubble on flush or stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_ctrl_q     <= CTRL_BUBBLE;
            ex_rs_q       <= '0;
            ex_rt_q       <= '0;
            ex_rd_q       <= '0;
            mem_q         <= '0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_dst_q      <= '0;
        end else begin
            if (taken || stall) begin
                ex_ctrl_q <= CTRL_BUBBLE;
                ex_rs_q   <= '0;
                ex_rt_q   <= '0;
                ex_rd_q   <= '0;
            end else begin
                ex_ctrl_q <= ctrl_sanitize(bus.id_ctrl);
                ex_rs_q   <= bus.id_rs;
                ex_rt_q   <= bus.id_rt;
                ex_rd_q   <= bus.id_rd;
            end
            mem_q.memread  <= ex_ctrl_q[B_MEMREAD];
            mem_q.memwrite <= ex_ctrl_q[B_MEMWRITE];
            mem_q.memtoreg <= ex_ctrl_q[B_MEMTOREG];
            mem_q.regwrite <= ex_ctrl_q[B_REGWRITE];
            mem_q.dst      <= ex_dst;
            wb_regwrite_q  <= mem_q.regwrite;
            wb_memtoreg_q  <= mem_q.memtoreg;
            wb_dst_q       <= mem_q.dst;
        end
    end

    mips_fwd_unit u_fwd (
        .mem_regwrite (mem_q.regwrite),
        .mem_dst      (mem_q.dst),
        .wb_regwrite  (wb_regwrite_q),
        .wb_dst       (wb_dst_q),
        .ex_rs        (ex_rs_q),
        .ex_rt        (ex_rt_q),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    assign bus.stall        = stall;
    assign bus.flush        = taken;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.mem_memread  = mem_q.memread;
    assign bus.mem_memwrite = mem_q.memwrite;
    assign bus.mem_regwrite = mem_q.regwrite;
    assign bus.mem_memtoreg = mem_q.memtoreg;
    assign bus.mem_dst      = mem_q.dst;
    assign bus.wb_regwrite  = wb_regwrite_q;
    assign bus.wb_memtoreg  = wb_memtoreg_q;
    assign bus.wb_dst       = wb_dst_q;
    assign bus.fwd_a        = fwd_a;
    assign bus.fwd_b        = fwd_b;

`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (taken && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/mips_ctrl_pipe.md
Name: mips_ctrl_pipe

Overview:
- Consumer side of the decoded control bundle. Receives the ID-stage control word from the opcode decoder.
- Carries the control word through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves branches and jumps in EX, detects load-use hazards and generates forwarding selects.
- Sits between the decoder and the datapath stage registers; drives PC/IF-ID hold and squash.

Parameters:
- REG_AW, 5, register-address width.
- CTRL_W, 13, packed control width {RegDst,J,Beq,Bneq,MemRead,MemtoReg,MemWrite,RegWrite,Alu_src[1:0],Alu_op[2:0]}, MSB first.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- id_ctrl  in  CTRL_W  decoder control word for the instruction in ID.
- id_rs  in  REG_AW  ID source register rs.
- id_rt  in  REG_AW  ID source register rt.
- id_rd  in  REG_AW  ID destination register rd.
- ex_zero  in  1  ALU zero flag of the instruction in EX.
- stall  out  1  hold PC and IF/ID (load-use).
- flush  out  1  squash IF/ID (taken branch or jump in EX).
- ex_ctrl  out  CTRL_W  ID/EX control word.
- ex_rs  out  REG_AW  ID/EX rs.
- ex_rt  out  REG_AW  ID/EX rt.
- mem_memread  out  1  EX/MEM MemRead.
- mem_memwrite  out  1  EX/MEM MemWrite.
- mem_regwrite  out  1  EX/MEM RegWrite.
- mem_memtoreg  out  1  EX/MEM MemtoReg.
- mem_dst  out  REG_AW  EX/MEM destination register.
- wb_regwrite  out  1  MEM/WB RegWrite.
- wb_memtoreg  out  1  MEM/WB MemtoReg.
- wb_dst  out  REG_AW  MEM/WB destination register.
- fwd_a  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  ALU operand B select, same encoding.

Behaviour:
- Reset (reset=0, asynchronous): all stage registers load the bubble (all zero). stall=0, flush=0, fwd_a=fwd_b=00. This holds on reset mid-operation; there is no drain.
- Latency: a control word reaches EX 1 cycle after ID, MEM after 2 cycles, WB after 3.
- Sanitize on ID/EX capture:
  - RegDst and MemtoReg are forced 0 when RegWrite=0.
  - Alu_op and Alu_src are forced 0 when J=1.
  - Decoder don't-cares never propagate.
- ex_dst (internal) = RegDst ? rd : rt.
- Taken-branch/jump signal (combinational from ID/EX): taken = J | (Beq & ex_zero) | (Bneq & ~ex_zero). flush = taken.
- rt use: ID uses rt when Alu_src==00 or MemWrite=1.
- Load-use: stall = ex MemRead & ex_dst!=0 & (ex_dst==id_rs | (ex_dst==id_rt & ID uses rt)) & ~flush. Flush has priority over stall.
- ID/EX update each clk:
  - bubble if flush or stall;
  - else sanitized id_ctrl, id_rs, id_rt, id_rd.
- EX/MEM update each clk: MemRead, MemWrite, MemtoReg, RegWrite and ex_dst from ID/EX. Branch, jump and ALU fields are dropped.
- MEM/WB update each clk: MemtoReg, RegWrite, dst from EX/MEM.
- fwd_a (same rule for fwd_b with ex_rt):
  - 10 if mem_regwrite & mem_dst!=0 & mem_dst==ex_rs;
  - else 01 if wb_regwrite & wb_dst!=0 & wb_dst==ex_rs;
  - else 00.
  - EX/MEM wins when both match.
- Register $0 never causes a stall or a forward.
- Branch penalty: 2 cycles. The instructions in IF/ID and ID are squashed.

Optional Feature:
- Macro: CTRL_PIPE_PERF_EN.
- When defined:
  - Extra outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Each counter increments in every cycle its signal is 1 and saturates at 16'hFFFF.
  - Both counters clear on reset.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_ctrl_pkg holds:
  - CTRL_W and bit-index localparams for each bundle field;
  - FWD_REG=00, FWD_MEM=10, FWD_WB=01;
  - the CTRL_BUBBLE constant.
- Natural sub-module: mips_fwd_unit, the combinational fwd_a/fwd_b logic. The hazard, flush and stage registers stay in the top.

Test Plan:
- Drive reset=0 mid-stream with non-zero stages -> all ctrl, dst and fwd outputs 0 immediately, stall=flush=0.
- lw $2 followed by add $3,$2,$4 -> stall=1 for exactly 1 cycle, ex_ctrl bubble, next cycle add in EX with fwd_a=01.
- add $2,$1,$1 then sub $5,$2,$2 back-to-back -> fwd_a=fwd_b=10 while sub is in EX.
- beq in EX with ex_zero=1 -> flush=1 for 1 cycle, next ex_ctrl=0; bne with ex_zero=1 -> flush=0.
- j in EX while ID holds a load-use consumer -> flush=1, stall=0, ID/EX bubble.
- lw $0 then add using $0 -> stall=0, fwd_a=fwd_b=00.
